multicycle_add_sub: RTL and testbench

//   Parametrised sequential successor to the ripple-carry N-bit adder.

---
 rtl/multicycle_add_sub.sv | 120 ++++++++++++
 tb/tb_multicycle_add_sub.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_add_sub.sv
// rtl/multicycle_add_sub.sv - chunked sequential adder/subtractor
// Processes CHUNK bits per clock; carry is held in a register between chunks.
module multicycle_add_sub #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int NCHUNK = N / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);
  localparam logic [N-1:0]  CHUNK_MASK = N'({CHUNK{1'b1}});

  generate
    if ((N % CHUNK) != 0) begin : g_bad_chunk
      $error("multicycle_add_sub: N must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [N-1:0]    r_res;

  logic [31:0]     w_shift;
  logic [N-1:0]    w_a_sh;
  logic [N-1:0]    w_b_sh;
  logic [CHUNK:0]  w_chunk_sum;
  logic [N-1:0]    w_res_next;
  logic            w_ovf_next;
  logic            w_accept;

  // Current chunk is selected by shifting the operands down by idx*CHUNK.
  always_comb begin
    w_shift     = 32'(r_idx) * 32'(CHUNK);
    w_a_sh      = r_a >> w_shift;
    w_b_sh      = r_b >> w_shift;
    w_chunk_sum = {1'b0, w_a_sh[CHUNK-1:0]} + {1'b0, w_b_sh[CHUNK-1:0]}
                + (CHUNK+1)'(r_carry);
    w_res_next  = (r_res & ~(CHUNK_MASK << w_shift))
                | (N'(w_chunk_sum[CHUNK-1:0]) << w_shift);
    w_ovf_next  = (r_a[N-1] == r_b[N-1]) && (w_res_next[N-1] != r_a[N-1]);
  end

  assign w_accept = start && !busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_res   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (w_accept) begin
            // Subtraction is a + ~b + 1, so b is inverted once at accept.
            r_a     <= a;
            r_b     <= b ^ {N{mode}};
            r_carry <= mode ? 1'b1 : cin;
            r_idx   <= '0;
            r_res   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_chunk_sum[CHUNK];
          if (r_idx == LAST_IDX) begin
            sum     <= w_res_next;
            cout    <= w_chunk_sum[CHUNK];
            ovf     <= w_ovf_next;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_add_sub.sv
// tb/tb_multicycle_add_sub.sv - self-checking bench for multicycle_add_sub
// Two instances: CHUNK=4 (four-cycle latency) and CHUNK=16 (single-cycle).
module tb_multicycle_add_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic        mode, cin;
  logic [15:0] a, b;
  logic        busy0, done0, cout0, ovf0;
  logic        busy1, done1, cout1, ovf1;
  logic [15:0] sum0, sum1;

  logic        cur_sel;
  logic        busy_s, done_s, cout_s, ovf_s;
  logic [15:0] sum_s;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  multicycle_add_sub #(.N(16), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  multicycle_add_sub #(.N(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  always_comb begin
    busy_s = cur_sel ? busy1 : busy0;
    done_s = cur_sel ? done1 : done0;
    sum_s  = cur_sel ? sum1  : sum0;
    cout_s = cur_sel ? cout1 : cout0;
    ovf_s  = cur_sel ? ovf1  : ovf0;
  end

  // Reference: unsigned result/carry and signed overflow from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic m, input logic c);
    int ux, uy, t, sr;
    logic [15:0] s;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    if (m) begin
      t  = ux - uy;
      co = (ux >= uy);
      sr = int'($signed(x)) - int'($signed(y));
    end else begin
      t  = ux + uy + int'(c);
      co = (t > 65535);
      sr = int'($signed(x)) + int'($signed(y)) + int'(c);
    end
    s  = 16'(t);
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic sel, input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  // Waits up to 20 cycles for done; returns the cycle count since the accept edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done_s) break;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] x, input logic [15:0] y,
                              input logic m, input logic c, input int lat, input int exp_lat);
    logic [17:0] e;
    e = model(x, y, m, c);
    chk({tag, ".lat"},  32'(lat),    32'(exp_lat));
    chk({tag, ".done"}, 32'(done_s), 32'd1);
    chk({tag, ".busy"}, 32'(busy_s), 32'd0);
    chk({tag, ".sum"},  32'(sum_s),  32'(e[15:0]));
    chk({tag, ".cout"}, 32'(cout_s), 32'(e[16]));
    chk({tag, ".ovf"},  32'(ovf_s),  32'(e[17]));
  endtask

  task automatic run_op(input logic sel, input logic [15:0] x, input logic [15:0] y,
                        input logic m, input logic c, input int exp_lat, input string tag);
    int lat;
    cur_sel = sel;
    @(negedge clk);
    a = x; b = y; mode = m; cin = c;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    chk({tag, ".busy_run"}, 32'(busy_s), 32'd1);
    chk({tag, ".done_run"}, 32'(done_s), 32'd0);
    @(negedge clk);
    set_start(sel, 1'b0);
    wait_done(lat);
    check_result(tag, x, y, m, c, lat, exp_lat);
  endtask

  initial begin
    logic [15:0] ra, rb, xa, xb;
    logic        rm, rc;
    logic [17:0] e;
    int          lat, ndone;
    logic [15:0] cap_sum;

    cur_sel = 1'b0;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    mode = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy0", 32'(busy0), 32'd0);
    chk("rst.done0", 32'(done0), 32'd0);
    chk("rst.sum0",  32'(sum0),  32'd0);
    chk("rst.cout0", 32'(cout0), 32'd0);
    chk("rst.ovf0",  32'(ovf0),  32'd0);
    chk("rst.busy1", 32'(busy1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed corner cases
    run_op(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, 4, "add_5555");
    chk("add_5555.const", 32'(sum0), 32'h5555);
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 4, "add_wrap");
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 4, "add_ovf");
    chk("add_ovf.const", 32'(ovf0), 32'd1);
    run_op(1'b0, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 4, "add_cin_ovf");
    run_op(1'b0, 16'h8000, 16'h0001, 1'b1, 1'b0, 4, "sub_ovf");
    chk("sub_ovf.const", 32'(sum0), 32'h7FFF);
    run_op(1'b0, 16'h0000, 16'h0001, 1'b1, 1'b1, 4, "sub_borrow");
    chk("sub_borrow.cout", 32'(cout0), 32'd0);
    run_op(1'b0, 16'h0000, 16'h8000, 1'b1, 1'b0, 4, "sub_minint");

    // Result held after done
    e = model(16'h0000, 16'h8000, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold.sum",  32'(sum0),  32'(e[15:0]));
    chk("hold.done", 32'(done0), 32'd0);

    // Random operations on the chunked instance
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rm = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      run_op(1'b0, ra, rb, rm, rc, 4, $sformatf("rnd4_%0d", i));
    end

    // Start while busy must be ignored
    cur_sel = 1'b0;
    xa = 16'hA5A5; xb = 16'h1111;
    @(negedge clk);
    a = xa; b = xb; mode = 1'b0; cin = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h7777; mode = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    ndone = 0; cap_sum = '0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done0) begin
        ndone++;
        cap_sum = sum0;
      end
    end
    e = model(xa, xb, 1'b0, 1'b1);
    chk("busy_ign.ndone", 32'(ndone),   32'd1);
    chk("busy_ign.sum",   32'(cap_sum), 32'(e[15:0]));

    // Reset two cycles into RUN aborts the operation
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; mode = 1'b0; cin = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid.busy", 32'(busy0), 32'd0);
    chk("rst_mid.done", 32'(done0), 32'd0);
    chk("rst_mid.sum",  32'(sum0),  32'd0);
    chk("rst_mid.cout", 32'(cout0), 32'd0);
    chk("rst_mid.ovf",  32'(ovf0),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 16'h0101, 16'h0202, 1'b0, 1'b0, 4, "post_rst");

    // Back-to-back: start asserted during the done cycle
    run_op(1'b0, 16'h4000, 16'h4000, 1'b0, 1'b0, 4, "b2b_first");
    xa = 16'h1357; xb = 16'h2468;
    a = xa; b = xb; mode = 1'b1; cin = 1'b0; start0 = 1'b1;
    @(posedge clk); #1;
    chk("b2b.done_drop", 32'(done0), 32'd0);
    chk("b2b.busy",      32'(busy0), 32'd1);
    @(negedge clk);
    start0 = 1'b0;
    wait_done(lat);
    check_result("b2b_second", xa, xb, 1'b1, 1'b0, lat, 4);

    // Single-cycle instance
    run_op(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1, "c16_add");
    run_op(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0, 1, "c16_sub");
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rm = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      run_op(1'b1, ra, rb, rm, rc, 1, $sformatf("rnd16_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
